cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
- Run-control sequencer for the RISC_SPM CPU on the DE10-Lite board.
- Replaces the free-running slow clock with a one-cycle clock-enable pulse (cpu_en) on the 50 MHz domain.
- Modes (selected by switches): halt, continuous run at a divided rate, single-tick step, single-instruction step.
- Includes a PC breakpoint and a debounced step button. Status outputs drive LEDs.

Parameters:
- DIV_COUNT, 25000000: clk cycles per run-rate tick (divider period).
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required to accept a button level (20 ms at 50 MHz).
- FETCH_STATE, 4'd1: CPU State code of the first fetch state (instruction boundary).
- MAX_STEP_TICKS, 16: tick limit for one instruction step before aborting.

Ports:
- clk  in  1  system clock (MAX10_CLK1_50).
- rst  in  1  synchronous reset, active-low.
- step_n  in  1  raw step pushbutton, active-low (KEY[1]), asynchronous.
- mode  in  2  raw switch mode: 00 halt, 01 run, 10 tick-step, 11 instr-step; asynchronous.
- bp_en  in  1  breakpoint enable (switch), asynchronous.
- bp_addr  in  8  breakpoint PC value.
- pc  in  8  CPU PC.
- cpu_state  in  4  CPU State.
- cpu_en  out  1  registered one-cycle CPU clock-enable pulse.
- halted  out  1  high in IDLE or BREAK.
- bp_hit  out  1  high in BREAK.
- step_err  out  1  sticky: instruction step hit MAX_STEP_TICKS.
- run_state  out  3  FSM state code: IDLE 0, RUNNING 1, STEP_T 2, STEP_I 3, BREAK 4.
- tick_cnt  out  16  count of cpu_en pulses issued; wraps at 0xFFFF -> 0.

Behaviour:
- Reset (rst low at a clk edge):
  - FSM goes to IDLE.
  - cpu_en=0, bp_hit=0, step_err=0, tick_cnt=0, halted=1, run_state=0.
  - Divider, debounce counter and synchronisers clear. Debounced button reads released.
  - A reset during any step or run aborts it with no further cpu_en.
- Input synchronisation:
  - step_n, mode and bp_en each pass through 2 flip-flops before use.
  - pc, bp_addr and cpu_state are same-domain and used directly.
- Debounce:
  - The counter increments while the synced button differs from the stable level, and clears otherwise.
  - When the counter reaches DEBOUNCE_CYCLES-1, the stable level updates and the counter clears.
  - press is a 1-cycle pulse on each stable released->pressed transition.
- Divider:
  - div_cnt runs 0..DIV_COUNT-1 continuously.
  - div_tick is high when div_cnt==DIV_COUNT-1.
- General rules:
  - cpu_en is registered: a decision made in cycle N appears as cpu_en in cycle N+1.
  - Every cpu_en pulse increments tick_cnt.
  - cpu_en is never high for 2 consecutive cycles.
- Global override: if synced mode no longer matches the mode that entered the current state (RUNNING=01, STEP_T=10, STEP_I=11, BREAK=01), the FSM goes to IDLE next cycle and issues no cpu_en. This rule has priority over all other transitions.
- IDLE:
  - mode 01 -> RUNNING.
  - mode 10 with press -> STEP_T.
  - mode 11 with press -> STEP_I, and the step counter clears.
  - press in mode 00 is ignored.
- RUNNING: on each div_tick:
  - If bp_en && pc==bp_addr && cpu_state==FETCH_STATE && !bp_skip: go to BREAK, no pulse.
  - Otherwise issue cpu_en.
- BREAK:
  - No cpu_en.
  - press -> RUNNING with bp_skip=1.
  - bp_skip clears on the first cycle where pc!=bp_addr, so the breakpoint re-arms after leaving that address.
  - bp_skip also clears on reset and on entry to IDLE.
- STEP_T: issues exactly one cpu_en (in the cycle after entry), then returns to IDLE.
- STEP_I: on each div_tick, checked in this order:
  - If at least one pulse has been issued in this step and cpu_state==FETCH_STATE: go to IDLE.
  - Else if step ticks==MAX_STEP_TICKS: set step_err, go to IDLE.
  - Else issue cpu_en and increment step ticks.
  - step_err clears on reset or on the next successful instruction step.
- Simultaneous events:
  - press while RUNNING or STEP_* is ignored.
  - A breakpoint is evaluated only in RUNNING; steps ignore it.
  - A mode change and div_tick in the same cycle: the mode change wins.

Test Plan (DIV_COUNT=4, DEBOUNCE_CYCLES=3, FETCH_STATE=1, MAX_STEP_TICKS=4):
1. Reset, mode=01, pc=0x00, bp_en=0 -> cpu_en pulses every 4 cycles; tick_cnt=5 after 5 pulses; halted=0, run_state=1.
2. mode=10, pulse step_n low for 2 cycles -> no press (bounce rejected). Hold low for 6 cycles -> exactly one cpu_en, tick_cnt+1, FSM back in IDLE (run_state=0).
3. mode=11, press; cpu_state sequence 1,2,3,1 driven on successive pulses -> exactly 3 cpu_en, then IDLE, step_err=0.
4. mode=11, press with cpu_state stuck at 2 -> 4 cpu_en, then step_err=1 and halted=1.
5. mode=01, bp_en=1, bp_addr=0x05; pc steps to 0x05 with cpu_state=1 -> no pulse on that div_tick, run_state=4, bp_hit=1. Press -> RUNNING, pulses resume; no re-break until pc leaves 0x05 and returns.
6. mode=01 running, drive rst low for 1 cycle mid-period -> next cycle cpu_en=0, tick_cnt=0, run_state=0. Switch mode to 00 during STEP_I -> IDLE with no further cpu_en.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer for the RISC_SPM CPU: turns switch modes, a debounced step
// button and a PC breakpoint into single-cycle CPU clock-enable pulses.
module cpu_run_ctrl #(
  parameter int         DIV_COUNT       = 25000000,
  parameter int         DEBOUNCE_CYCLES = 1000000,
  parameter logic [3:0] FETCH_STATE     = 4'd1,
  parameter int         MAX_STEP_TICKS  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step_n,
  input  logic [1:0]  mode,
  input  logic        bp_en,
  input  logic [7:0]  bp_addr,
  input  logic [7:0]  pc,
  input  logic [3:0]  cpu_state,
  output logic        cpu_en,
  output logic        halted,
  output logic        bp_hit,
  output logic        step_err,
  output logic [2:0]  run_state,
  output logic [15:0] tick_cnt
);

  localparam int DIV_W = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SC_W  = $clog2(MAX_STEP_TICKS + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP_T = 3'd2,
    S_STEP_I = 3'd3,
    S_BREAK  = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [1:0]        step_sync;
  logic [1:0]        mode_s1, mode_s2;
  logic              bp_s1, bp_s2;
  logic              db_level;
  logic [DB_W-1:0]   db_cnt;
  logic              press;
  logic [DIV_W-1:0]  div_cnt;
  logic              div_tick;
  logic [SC_W-1:0]   step_cnt, step_cnt_n;
  logic              step_err_n;
  logic              bp_skip, bp_skip_n;
  logic              en_n;
  logic [1:0]        entry_mode;
  logic              bp_match;

  // Two-flop synchronisers; the button idles released (high).
  always_ff @(posedge clk) begin
    if (!rst) begin
      step_sync <= 2'b11;
      mode_s1   <= 2'b00;
      mode_s2   <= 2'b00;
      bp_s1     <= 1'b0;
      bp_s2     <= 1'b0;
    end else begin
      step_sync <= {step_sync[0], step_n};
      mode_s1   <= mode;
      mode_s2   <= mode_s1;
      bp_s1     <= bp_en;
      bp_s2     <= bp_s1;
    end
  end

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (!rst) begin
      db_level <= 1'b1;
      db_cnt   <= '0;
      press    <= 1'b0;
    end else begin
      press <= 1'b0;
      if (step_sync[1] != db_level) begin
        if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_level <= step_sync[1];
          db_cnt   <= '0;
          press    <= ~step_sync[1];
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (div_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign div_tick = (div_cnt == DIV_W'(DIV_COUNT - 1));

  always_comb begin
    entry_mode = 2'b00;
    case (state)
      S_RUN, S_BREAK: entry_mode = 2'b01;
      S_STEP_T:       entry_mode = 2'b10;
      S_STEP_I:       entry_mode = 2'b11;
      default:        entry_mode = 2'b00;
    endcase
  end

  assign bp_match = bp_s2 && (pc == bp_addr) && (cpu_state == FETCH_STATE) && !bp_skip;

  always_comb begin
    state_n    = state;
    en_n       = 1'b0;
    step_cnt_n = step_cnt;
    step_err_n = step_err;
    bp_skip_n  = bp_skip;
    // Leaving the mode that started a state aborts it before anything else is considered.
    if (state != S_IDLE && mode_s2 != entry_mode) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (mode_s2 == 2'b01) begin
            state_n = S_RUN;
          end else if (press && mode_s2 == 2'b10) begin
            state_n = S_STEP_T;
          end else if (press && mode_s2 == 2'b11) begin
            state_n    = S_STEP_I;
            step_cnt_n = '0;
          end
        end
        S_RUN: begin
          if (div_tick) begin
            if (bp_match) state_n = S_BREAK;
            else          en_n    = 1'b1;
          end
        end
        S_BREAK: begin
          if (press) begin
            state_n   = S_RUN;
            bp_skip_n = 1'b1;
          end
        end
        S_STEP_T: begin
          en_n    = 1'b1;
          state_n = S_IDLE;
        end
        S_STEP_I: begin
          if (div_tick) begin
            if (step_cnt != '0 && cpu_state == FETCH_STATE) begin
              state_n    = S_IDLE;
              step_err_n = 1'b0;
            end else if (step_cnt == SC_W'(MAX_STEP_TICKS)) begin
              state_n    = S_IDLE;
              step_err_n = 1'b1;
            end else begin
              en_n       = 1'b1;
              step_cnt_n = step_cnt + 1'b1;
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
    // The skip only covers the address we broke on; it re-arms once the PC moves away.
    if (pc != bp_addr)     bp_skip_n = 1'b0;
    if (state_n == S_IDLE) bp_skip_n = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      cpu_en   <= 1'b0;
      tick_cnt <= '0;
      step_cnt <= '0;
      step_err <= 1'b0;
      bp_skip  <= 1'b0;
    end else begin
      state    <= state_n;
      cpu_en   <= en_n;
      tick_cnt <= tick_cnt + {15'd0, en_n};
      step_cnt <= step_cnt_n;
      step_err <= step_err_n;
      bp_skip  <= bp_skip_n;
    end
  end

  assign halted    = (state == S_IDLE) || (state == S_BREAK);
  assign bp_hit    = (state == S_BREAK);
  assign run_state = state;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios against fixed expectations plus a
// randomized run checked cycle by cycle against a behavioural model.
module tb_cpu_run_ctrl;

  localparam int DIV   = 4;
  localparam int DB    = 3;
  localparam int FETCH = 1;
  localparam int MAXT  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        step_n = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic        bp_en = 1'b0;
  logic [7:0]  bp_addr = 8'd0;
  logic [7:0]  pc = 8'd0;
  logic [3:0]  cpu_state = 4'd0;
  logic        cpu_en, halted, bp_hit, step_err;
  logic [2:0]  run_state;
  logic [15:0] tick_cnt;

  int total = 0;
  int bad = 0;
  logic [3:0] seq_tab [3];

  cpu_run_ctrl #(
    .DIV_COUNT(DIV), .DEBOUNCE_CYCLES(DB), .FETCH_STATE(4'(FETCH)), .MAX_STEP_TICKS(MAXT)
  ) dut (
    .clk(clk), .rst(rst), .step_n(step_n), .mode(mode), .bp_en(bp_en),
    .bp_addr(bp_addr), .pc(pc), .cpu_state(cpu_state), .cpu_en(cpu_en),
    .halted(halted), .bp_hit(bp_hit), .step_err(step_err),
    .run_state(run_state), .tick_cnt(tick_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  // Behavioural reference: modes as plain integers 0..4, counts as ints.
  int m_st, m_scnt, m_run, m_cyc, m_ticks, mx_want, mx_nx;
  bit m_en, m_err, m_skip, m_level, m_press, mx_en, mx_resume, mx_pn, mx_match;
  bit [1:0] sy_step, sy_bp;
  int sy_mode [2];

  always @(posedge clk) begin
    if (!rst) begin
      m_st = 0; m_en = 0; m_ticks = 0; m_err = 0; m_skip = 0; m_scnt = 0;
      sy_step = 2'b11; sy_bp = 2'b00; sy_mode[0] = 0; sy_mode[1] = 0;
      m_level = 1; m_run = 0; m_press = 0; m_cyc = 0;
    end else begin
      mx_want = (m_st == 1 || m_st == 4) ? 1 : (m_st == 2) ? 2 : (m_st == 3) ? 3 : 0;
      mx_en = 0; mx_resume = 0; mx_nx = m_st;
      mx_match = sy_bp[1] && (pc == bp_addr) && (cpu_state == FETCH) && !m_skip;
      if (m_st != 0 && sy_mode[1] != mx_want) mx_nx = 0;
      else if (m_st == 0) begin
        if (sy_mode[1] == 1) mx_nx = 1;
        else if (m_press && sy_mode[1] == 2) mx_nx = 2;
        else if (m_press && sy_mode[1] == 3) begin mx_nx = 3; m_scnt = 0; end
      end else if (m_st == 1) begin
        if ((m_cyc % DIV) == DIV - 1) begin
          if (mx_match) mx_nx = 4; else mx_en = 1;
        end
      end else if (m_st == 4) begin
        if (m_press) begin mx_nx = 1; mx_resume = 1; end
      end else if (m_st == 2) begin
        mx_en = 1; mx_nx = 0;
      end else if (m_st == 3 && (m_cyc % DIV) == DIV - 1) begin
        if (m_scnt > 0 && cpu_state == FETCH) begin mx_nx = 0; m_err = 0; end
        else if (m_scnt == MAXT) begin mx_nx = 0; m_err = 1; end
        else begin mx_en = 1; m_scnt++; end
      end
      if (mx_resume) m_skip = 1;
      if (pc != bp_addr) m_skip = 0;
      if (mx_nx == 0) m_skip = 0;
      m_st = mx_nx;
      m_en = mx_en;
      m_ticks = (m_ticks + int'(mx_en)) & 16'hFFFF;
      mx_pn = 0;
      if (sy_step[1] != m_level) begin
        m_run++;
        if (m_run == DB) begin m_level = sy_step[1]; mx_pn = !m_level; m_run = 0; end
      end else m_run = 0;
      m_press = mx_pn;
      sy_step = {sy_step[0], step_n};
      sy_bp = {sy_bp[0], bp_en};
      sy_mode[1] = sy_mode[0]; sy_mode[0] = int'(mode);
      m_cyc++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Holds the button for 'hold' cycles, counts pulses over 'span' cycles and
  // advances cpu_state through seq_tab on each pulse like a stepping CPU would.
  task automatic press_and_count(input int hold, input int span, input int nseq, output int pulses);
    int idx = 0;
    pulses = 0;
    step_n = 1'b0;
    for (int i = 0; i < span; i++) begin
      @(negedge clk);
      if (i == hold - 1) step_n = 1'b1;
      if (cpu_en) begin
        pulses++;
        if (idx < nseq) begin cpu_state = seq_tab[idx]; idx++; end
      end
    end
    step_n = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0; mode = 2'b00; step_n = 1'b1;
    cyc(3);
    total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL reset_cpu_en: got %0b want 0", cpu_en); end
    total++; if (tick_cnt !== 16'd0) begin bad++; $display("FAIL reset_tick_cnt: got %0d want 0", tick_cnt); end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL reset_halted: got %0b want 1", halted); end
    total++; if (bp_hit !== 1'b0 || step_err !== 1'b0) begin bad++; $display("FAIL reset_flags: bp_hit=%0b step_err=%0b want 0 0", bp_hit, step_err); end
    total++; if (run_state !== 3'd0) begin bad++; $display("FAIL reset_run_state: got %0d want 0", run_state); end
    rst = 1'b1;
    cyc(1);
  endtask

  task automatic test_run;
    int pulses = 0, last = 0, gap_bad = 0;
    mode = 2'b01; pc = 8'd0; bp_en = 1'b0; cpu_state = 4'd0;
    for (int i = 0; i < 200 && pulses < 5; i++) begin
      @(negedge clk);
      if (cpu_en) begin
        if (pulses > 0 && i - last != DIV) gap_bad++;
        last = i; pulses++;
      end
    end
    total++; if (pulses != 5) begin bad++; $display("FAIL run_pulses: got %0d want 5", pulses); end
    total++; if (gap_bad != 0) begin bad++; $display("FAIL run_period: got %0d bad gaps want 0", gap_bad); end
    total++; if (tick_cnt !== 16'd5) begin bad++; $display("FAIL run_tick_cnt: got %0d want 5", tick_cnt); end
    total++; if (halted !== 1'b0 || run_state !== 3'd1) begin bad++; $display("FAIL run_status: halted=%0b run_state=%0d want 0 1", halted, run_state); end
  endtask

  task automatic test_tick_step;
    int p;
    logic [15:0] t0;
    mode = 2'b00; cyc(4);
    mode = 2'b10; cyc(3);
    t0 = tick_cnt;
    press_and_count(2, 14, 0, p);
    total++; if (p != 0 || tick_cnt !== t0) begin bad++; $display("FAIL bounce_reject: pulses=%0d tick=%0d want 0 %0d", p, tick_cnt, t0); end
    press_and_count(6, 20, 0, p);
    total++; if (p != 1) begin bad++; $display("FAIL tick_step_pulses: got %0d want 1", p); end
    total++; if (tick_cnt !== t0 + 16'd1) begin bad++; $display("FAIL tick_step_cnt: got %0d want %0d", tick_cnt, t0 + 16'd1); end
    total++; if (run_state !== 3'd0) begin bad++; $display("FAIL tick_step_idle: got %0d want 0", run_state); end
  endtask

  task automatic test_instr_step;
    int p;
    logic [15:0] t0;
    mode = 2'b11; cpu_state = 4'd1; cyc(3);
    t0 = tick_cnt;
    seq_tab[0] = 4'd2; seq_tab[1] = 4'd3; seq_tab[2] = 4'd1;
    press_and_count(6, 60, 3, p);
    total++; if (p != 3) begin bad++; $display("FAIL istep_pulses: got %0d want 3", p); end
    total++; if (run_state !== 3'd0 || step_err !== 1'b0) begin bad++; $display("FAIL istep_end: run_state=%0d step_err=%0b want 0 0", run_state, step_err); end
    total++; if (tick_cnt !== t0 + 16'd3) begin bad++; $display("FAIL istep_cnt: got %0d want %0d", tick_cnt, t0 + 16'd3); end
  endtask

  task automatic test_step_abort;
    int p;
    cpu_state = 4'd2;
    press_and_count(6, 60, 0, p);
    total++; if (p != MAXT) begin bad++; $display("FAIL abort_pulses: got %0d want %0d", p, MAXT); end
    total++; if (step_err !== 1'b1 || halted !== 1'b1) begin bad++; $display("FAIL abort_flags: step_err=%0b halted=%0b want 1 1", step_err, halted); end
    cpu_state = 4'd1;
    press_and_count(6, 40, 0, p);
    total++; if (p != 1 || step_err !== 1'b0) begin bad++; $display("FAIL err_clear: pulses=%0d step_err=%0b want 1 0", p, step_err); end
  endtask

  task automatic test_breakpoint;
    int p = 0;
    bp_addr = 8'h05; bp_en = 1'b1; pc = 8'd0; cpu_state = 4'd1; mode = 2'b01;
    for (int i = 0; i < 200 && run_state !== 3'd4; i++) begin
      @(negedge clk);
      if (cpu_en) pc = pc + 8'd1;
    end
    total++; if (run_state !== 3'd4 || pc !== 8'h05) begin bad++; $display("FAIL bp_break: run_state=%0d pc=%0d want 4 5", run_state, pc); end
    total++; if (bp_hit !== 1'b1 || halted !== 1'b1) begin bad++; $display("FAIL bp_flags: bp_hit=%0b halted=%0b want 1 1", bp_hit, halted); end
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (cpu_en) p++; end
    total++; if (p != 0) begin bad++; $display("FAIL bp_hold: got %0d pulses want 0", p); end
    step_n = 1'b0;
    for (int i = 0; i < 60 && p < 3; i++) begin
      @(negedge clk);
      if (i == 5) step_n = 1'b1;
      if (cpu_en) begin pc = pc + 8'd1; p++; end
    end
    step_n = 1'b1;
    total++; if (p != 3 || pc !== 8'd8 || run_state !== 3'd1) begin bad++; $display("FAIL bp_resume: pulses=%0d pc=%0d state=%0d want 3 8 1", p, pc, run_state); end
    pc = 8'h05; p = 0;
    for (int i = 0; i < 40 && run_state !== 3'd4; i++) begin @(negedge clk); if (cpu_en) p++; end
    total++; if (run_state !== 3'd4 || p != 0) begin bad++; $display("FAIL bp_rearm: state=%0d pulses=%0d want 4 0", run_state, p); end
    mode = 2'b00; bp_en = 1'b0; cyc(4);
  endtask

  task automatic test_reset_mid_run;
    int seen = 0;
    mode = 2'b01; pc = 8'd0;
    for (int i = 0; i < 40 && seen == 0; i++) begin @(negedge clk); if (cpu_en) seen = 1; end
    cyc(2);
    rst = 1'b0;
    cyc(1);
    total++; if (seen != 1 || cpu_en !== 1'b0 || tick_cnt !== 16'd0) begin bad++; $display("FAIL mid_reset: seen=%0d cpu_en=%0b tick=%0d want 1 0 0", seen, cpu_en, tick_cnt); end
    total++; if (run_state !== 3'd0) begin bad++; $display("FAIL mid_reset_state: got %0d want 0", run_state); end
    rst = 1'b1;
  endtask

  task automatic test_mode_abort;
    int got = 0, p = 0;
    mode = 2'b11; cpu_state = 4'd2; cyc(4);
    step_n = 1'b0;
    for (int i = 0; i < 60 && got == 0; i++) begin
      @(negedge clk);
      if (i == 5) step_n = 1'b1;
      if (cpu_en) got = 1;
    end
    step_n = 1'b1;
    mode = 2'b00;
    for (int i = 0; i < 30; i++) begin @(negedge clk); if (cpu_en) p++; end
    total++; if (got != 1 || p != 0) begin bad++; $display("FAIL mode_abort: first=%0d later=%0d want 1 0", got, p); end
    total++; if (run_state !== 3'd0 || step_err !== 1'b0 || tick_cnt !== 16'd1) begin bad++; $display("FAIL mode_abort_state: state=%0d err=%0b tick=%0d want 0 0 1", run_state, step_err, tick_cnt); end
  endtask

  task automatic test_random;
    int hold = 0, b2b = 0;
    bit prev = 0;
    rst = 1'b0; bp_addr = 8'd3; cyc(2); rst = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      total++; if (cpu_en !== m_en) begin bad++; $display("FAIL rnd_cpu_en @%0d: got %0b want %0b", i, cpu_en, m_en); end
      total++; if (tick_cnt !== 16'(m_ticks)) begin bad++; $display("FAIL rnd_tick_cnt @%0d: got %0d want %0d", i, tick_cnt, m_ticks); end
      total++; if (run_state !== 3'(m_st)) begin bad++; $display("FAIL rnd_state @%0d: got %0d want %0d", i, run_state, m_st); end
      total++; if (step_err !== m_err) begin bad++; $display("FAIL rnd_step_err @%0d: got %0b want %0b", i, step_err, m_err); end
      total++; if (halted !== (m_st == 0 || m_st == 4) || bp_hit !== (m_st == 4)) begin bad++; $display("FAIL rnd_status @%0d: halted=%0b bp_hit=%0b model=%0d", i, halted, bp_hit, m_st); end
      if (prev && cpu_en) b2b++;
      prev = cpu_en;
      if (cpu_en) begin pc = 8'($urandom_range(0, 7)); cpu_state = 4'($urandom_range(0, 3)); end
      if (hold == 0) begin step_n = ~step_n; hold = $urandom_range(1, 6); end else hold--;
      if ($urandom_range(0, 79) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) bp_en = ~bp_en;
      rst = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
    end
    rst = 1'b1;
    total++; if (b2b != 0) begin bad++; $display("FAIL back_to_back: got %0d adjacent pulses want 0", b2b); end
  endtask

  initial begin
    test_reset;
    test_run;
    test_tick_step;
    test_instr_step;
    test_step_abort;
    test_breakpoint;
    test_reset_mid_run;
    test_mode_abort;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
